// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one outstanding
// imem request at a time (req/ack), presents the fetched word to the decoder
// (valid/ready) and computes the next PC when the word retires.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned next PC traps
// into FAULT instead of being silently aligned).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | just out of reset, request goes out next cycle
// FETCH  | imemReq high at pc, waiting for imemAck
// HOLD   | instr/pc presented with instrValid, waiting for instrReady
// FAULT  | misaligned target trapped (macro only), exits by reset only
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic [31:0] imemRdata,
  input  logic        imemAck,
  output logic [31:0] instr,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic [1:0]  pcSrcCtrl,
  input  logic [25:0] jAddr,
  input  logic [31:0] imm,
  input  logic [31:0] regRsData,
  input  logic        zero,
  input  logic        bneCtrl,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_FAULT
`endif
  } state_t;

  localparam logic [1:0] SRC_INC4 = 2'd0;
  localparam logic [1:0] SRC_JUMP = 2'd1;
  localparam logic [1:0] SRC_JR   = 2'd2;
  localparam logic [1:0] SRC_BR   = 2'd3;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] next_pc_aligned;
  logic        br_taken;

  assign imemAddr        = pc;
  assign pcPlus4         = pc + 32'd4;
  assign br_taken        = zero ^ bneCtrl;
  assign next_pc_aligned = next_pc & 32'hFFFF_FFFC;

  // Next-PC selection from the decoder/datapath; only consumed on retirement.
  always_comb begin
    next_pc = pcPlus4;
    case (pcSrcCtrl)
      SRC_INC4: next_pc = pcPlus4;
      SRC_JUMP: next_pc = {pcPlus4[31:28], jAddr, 2'b00};
      SRC_JR:   next_pc = regRsData;
      SRC_BR:   next_pc = br_taken ? (pcPlus4 + (imm << 2)) : pcPlus4;
      default:  next_pc = pcPlus4;
    endcase
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  // Fetch sequencer; all handshake outputs are registered with the state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      instrValid <= 1'b0;
      imemReq    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_FETCH;
          imemReq <= 1'b1;
        end
        ST_FETCH: begin
          if (imemAck) begin
            instr      <= imemRdata;
            instrValid <= 1'b1;
            imemReq    <= 1'b0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instrReady) begin
            instrValid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            // Keep the offending target in pc so it reads as the fault address.
            pc <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= ST_FAULT;
            end else begin
              imemReq <= 1'b1;
              state   <= ST_FETCH;
            end
`else
            pc      <= next_pc_aligned;
            imemReq <= 1'b1;
            state   <= ST_FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_FAULT: begin
          imemReq    <= 1'b0;
          instrValid <= 1'b0;
          misalign   <= 1'b1;
        end
`endif
        default: begin
          state      <= ST_IDLE;
          imemReq    <= 1'b0;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
`else
  // next_pc_aligned is only consumed in the non-trapping build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Expected fetch addresses are
// queued when a retirement is issued and popped when the DUT raises imemReq.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic [31:0] imemRdata;
  logic        imemAck;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [1:0]  pcSrcCtrl;
  logic [25:0] jAddr;
  logic [31:0] imm;
  logic [31:0] regRsData;
  logic        zero;
  logic        bneCtrl;
  logic        misalign;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_addr;
  logic [31:0] cur_word;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstN(rstN),
    .imemAddr(imemAddr), .imemReq(imemReq), .imemRdata(imemRdata), .imemAck(imemAck),
    .instr(instr), .instrValid(instrValid), .instrReady(instrReady),
    .pc(pc), .pcPlus4(pcPlus4),
    .pcSrcCtrl(pcSrcCtrl), .jAddr(jAddr), .imm(imm), .regRsData(regRsData),
    .zero(zero), .bneCtrl(bneCtrl), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Wait for a request, match its address against the scoreboard, ack after
  // 'delay' FETCH cycles and check the presented instruction.
  task automatic do_fetch(input int delay);
    int n = 0;
    logic [31:0] e;
    while (imemReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imemReq}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      e = 32'hXXXX_XXXX;
    end else begin
      e = exp_q.pop_front();
    end
    check("fetch_addr", imemAddr, e);
    cur_addr = e;
    cur_word = e ^ 32'h1357_9BDF;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_addr", imemAddr, e);
      check("wait_req", {31'd0, imemReq}, 32'd1);
      check("wait_valid", {31'd0, instrValid}, 32'd0);
    end
    imemAck   = 1'b1;
    imemRdata = cur_word;
    @(negedge clk);
    imemAck   = 1'b0;
    imemRdata = 32'hBAD0_BAD0;
    check("valid_after_ack", {31'd0, instrValid}, 32'd1);
    check("instr", instr, cur_word);
    check("pc", pc, e);
    check("pcplus4", pcPlus4, e + 32'd4);
    check("req_drop", {31'd0, imemReq}, 32'd0);
  endtask

  // Stall 'hold' cycles with stray acks, then retire with the given controls.
  task automatic retire(input int hold, input logic [1:0] src, input logic [25:0] ja,
                        input logic [31:0] im, input logic [31:0] rs, input logic z,
                        input logic bne, input logic [31:0] exp_next, input bit fault);
    for (int i = 0; i < hold; i++) begin
      instrReady = 1'b0;
      imemAck    = 1'b1;
      imemRdata  = 32'hBAD0_BAD0;
      pcSrcCtrl  = 2'($urandom_range(0, 3));
      @(negedge clk);
      imemAck = 1'b0;
      check("hold_valid", {31'd0, instrValid}, 32'd1);
      check("hold_instr", instr, cur_word);
      check("hold_pc", pc, cur_addr);
      check("hold_addr", imemAddr, cur_addr);
      check("hold_req", {31'd0, imemReq}, 32'd0);
    end
    pcSrcCtrl = src; jAddr = ja; imm = im; regRsData = rs; zero = z; bneCtrl = bne;
    instrReady = 1'b1;
    @(negedge clk);
    instrReady = 1'b0;
    pcSrcCtrl = 2'($urandom_range(0, 3)); regRsData = $urandom;
    check("valid_drop", {31'd0, instrValid}, 32'd0);
    if (fault) begin
      check("fault_misalign", {31'd0, misalign}, 32'd1);
      check("fault_pc", pc, exp_next);
      check("fault_req", {31'd0, imemReq}, 32'd0);
    end else begin
      check("redirect_req", {31'd0, imemReq}, 32'd1);
      exp_q.push_back(exp_next);
    end
  endtask

  initial begin
    rstN = 1'b0; imemAck = 1'b0; imemRdata = 32'h0; instrReady = 1'b0;
    pcSrcCtrl = 2'd0; jAddr = 26'd0; imm = 32'd0; regRsData = 32'd0; zero = 1'b0; bneCtrl = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_req", {31'd0, imemReq}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rstN = 1'b1;
    exp_q.push_back(32'h0);

    // Zero-wait sequential stream 0,4,8,C
    do_fetch(0); retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h4, 1'b0);
    do_fetch(0); retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8, 1'b0);
    do_fetch(0); retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hC, 1'b0);
    do_fetch(0);

    // Jump-register to 0x0040_0010, then jump with jAddr 0x010_0000
    retire(0, 2'd2, 26'd0, 32'd0, 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0010, 1'b0);
    do_fetch(0);
    retire(0, 2'd1, 26'h010_0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0040_0000, 1'b0);
    do_fetch(0);

    // Branch at 0x100 with imm -2: BEQ taken, then BNE not taken
    retire(0, 2'd2, 26'd0, 32'd0, 32'h100, 1'b0, 1'b0, 32'h100, 1'b0);
    do_fetch(0);
    retire(0, 2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, 32'hFC, 1'b0);
    do_fetch(0);
    retire(0, 2'd2, 26'd0, 32'd0, 32'h100, 1'b0, 1'b0, 32'h100, 1'b0);
    do_fetch(0);
    retire(0, 2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b1, 32'h104, 1'b0);

    // Slow memory and stalled decoder with stray acks
    do_fetch(3);
    retire(2, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h108, 1'b0);
    do_fetch(1);

    // PC wrap at the top of the address space
    retire(0, 2'd2, 26'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    do_fetch(0);
    retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(0);

    // Misaligned jump-register target
`ifdef FETCH_MISALIGN_TRAP_EN
    retire(0, 2'd2, 26'd0, 32'd0, 32'h0000_0202, 1'b0, 1'b0, 32'h202, 1'b1);
    imemAck = 1'b1;
    repeat (3) @(negedge clk);
    imemAck = 1'b0;
    check("fault_sticky", {31'd0, misalign}, 32'd1);
    check("fault_noreq", {31'd0, imemReq}, 32'd0);
    check("fault_novalid", {31'd0, instrValid}, 32'd0);
    rstN = 1'b0;
    @(negedge clk);
    check("fault_rst_clear", {31'd0, misalign}, 32'd0);
    rstN = 1'b1;
    exp_q.push_back(32'h0);
    do_fetch(0);
    retire(0, 2'd2, 26'd0, 32'd0, 32'h300, 1'b0, 1'b0, 32'h300, 1'b0);
`else
    retire(0, 2'd2, 26'd0, 32'd0, 32'h0000_0202, 1'b0, 1'b0, 32'h200, 1'b0);
    do_fetch(0);
    check("no_misalign", {31'd0, misalign}, 32'd0);
    retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h204, 1'b0);
`endif

    // Reset in the middle of a pending request
    check("midrst_req_before", {31'd0, imemReq}, 32'd1);
    if (exp_q.size() != 0) cur_addr = exp_q.pop_front();
    check("midrst_addr", imemAddr, cur_addr);
    imemAck = 1'b1;
    imemRdata = 32'hBAD0_BAD0;
    #1 rstN = 1'b0;
    #1;
    check("midrst_req_async", {31'd0, imemReq}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    check("midrst_instr", instr, 32'h0);
    rstN = 1'b1;
    exp_q.push_back(32'h0);
    do_fetch(0);
    retire(0, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h4, 1'b0);
    do_fetch(1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
